i2c_reg_ctrl: RTL and testbench

// - Register-map controller that sits beside i2c_slave and services its event outputs.
// - Turns I2C write transactions into a register pointer plus auto-incrementing register writes.
// - Drives i2c_slave.send_data from the register addressed by the pointer during reads.
// - Shares the register bank with a fabric-side host port; I2C has priority.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_reg_bank.sv | 48 ++++
 rtl/i2c_reg_ctrl.sv | 134 +++++++++++++
 tb/tb_i2c_reg_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-map controller: FSM encoding and counter width.
package i2c_pkg;

  localparam int CTRL_STATE_BITS = 3;
  localparam int XFER_CNT_W      = 16;

  typedef enum logic [CTRL_STATE_BITS-1:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_PTR      = 3'd3,
    ST_WDATA    = 3'd4,
    ST_RDATA    = 3'd5
  } ctrl_state_t;

  // A transaction counts as completed only once it got past the address ack.
  function automatic logic in_transfer(input ctrl_state_t s);
    return (s == ST_PTR) || (s == ST_WDATA) || (s == ST_RDATA);
  endfunction

endpackage

// File: rtl/i2c_reg_bank.sv
// NUM_REGS x 8 register bank: two write ports (port A wins) and two registered read ports.
module i2c_reg_bank
  import i2c_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_a,
  input  logic [ADDR_WIDTH-1:0] wr_addr_a,
  input  logic [7:0]            wr_data_a,
  input  logic                  wr_en_b,
  input  logic [ADDR_WIDTH-1:0] wr_addr_b,
  input  logic [7:0]            wr_data_b,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [7:0]            rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [7:0]            rd_data_b
);

  logic [7:0] regs_r [NUM_REGS];

  // Storage: port B is accepted only when port A is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else if (wr_en_a) begin
      regs_r[wr_addr_a] <= wr_data_a;
    end else if (wr_en_b) begin
      regs_r[wr_addr_b] <= wr_data_b;
    end
  end

  // Registered read ports, no write bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_a <= 8'h00;
      rd_data_b <= 8'h00;
    end else begin
      rd_data_a <= regs_r[rd_addr_a];
      rd_data_b <= regs_r[rd_addr_b];
    end
  end

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Register-map controller servicing i2c_slave events: pointer, auto-increment writes, read data.
module i2c_reg_ctrl
  import i2c_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i2c_start_cond,
  input  logic                  i2c_stop_cond,
  input  logic                  i2c_dev_addr_match,
  input  logic                  i2c_ack,
  input  logic                  i2c_nack,
  input  logic [7:0]            i2c_din,
  output logic [7:0]            i2c_send_data,
  input  logic                  host_wr_en,
  input  logic [ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [7:0]            host_wr_data,
  output logic                  host_wr_collision,
  input  logic [ADDR_WIDTH-1:0] host_rd_addr,
  output logic [7:0]            host_rd_data,
  output logic                  i2c_wr_strobe,
  output logic [ADDR_WIDTH-1:0] i2c_wr_addr,
  output logic                  busy,
  output logic [XFER_CNT_W-1:0] xfer_count
);

  ctrl_state_t           state_r, state_nxt_s;
  logic [ADDR_WIDTH-1:0] ptr_r, ptr_nxt_s;
  logic                  i2c_we_s;
  logic                  cnt_inc_s;
  logic                  host_we_s;

  // State, pointer and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r           <= ST_IDLE;
      ptr_r             <= '0;
      busy              <= 1'b0;
      i2c_wr_strobe     <= 1'b0;
      i2c_wr_addr       <= '0;
      host_wr_collision <= 1'b0;
      xfer_count        <= '0;
    end else begin
      state_r           <= state_nxt_s;
      ptr_r             <= ptr_nxt_s;
      busy              <= (state_nxt_s != ST_IDLE);
      i2c_wr_strobe     <= i2c_we_s;
      i2c_wr_addr       <= i2c_we_s ? ptr_r : i2c_wr_addr;
      host_wr_collision <= host_wr_en & i2c_we_s;
      xfer_count        <= cnt_inc_s ? xfer_count + 16'd1 : xfer_count;
    end
  end

  // Next-state logic; start beats stop, and both beat ack/nack.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    i2c_we_s    = 1'b0;
    cnt_inc_s   = 1'b0;
    if (i2c_start_cond) begin
      state_nxt_s = ST_ADDR;
      cnt_inc_s   = in_transfer(state_r);
    end else if (i2c_stop_cond) begin
      state_nxt_s = ST_IDLE;
      cnt_inc_s   = in_transfer(state_r);
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_ADDR: begin
          if (i2c_dev_addr_match) state_nxt_s = ST_ADDR_ACK;
          else                    state_nxt_s = ST_ADDR;
        end
        ST_ADDR_ACK: begin
          if (i2c_ack) state_nxt_s = i2c_din[0] ? ST_RDATA : ST_PTR;
          else         state_nxt_s = ST_ADDR_ACK;
        end
        ST_PTR: begin
          if (i2c_ack) begin
            state_nxt_s = ST_WDATA;
            ptr_nxt_s   = i2c_din[ADDR_WIDTH-1:0];
          end else begin
            state_nxt_s = ST_PTR;
          end
        end
        ST_WDATA: begin
          if (i2c_ack) begin
            i2c_we_s  = 1'b1;
            ptr_nxt_s = ptr_r + ADDR_WIDTH'(1);
          end else begin
            i2c_we_s  = 1'b0;
          end
        end
        ST_RDATA: begin
          if (i2c_ack) begin
            ptr_nxt_s = ptr_r + ADDR_WIDTH'(1);
          end else if (i2c_nack) begin
            ptr_nxt_s   = ptr_r + ADDR_WIDTH'(1);
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_RDATA;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  assign host_we_s = host_wr_en & ~i2c_we_s;

  i2c_reg_bank #(
    .NUM_REGS   (NUM_REGS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .wr_en_a   (i2c_we_s),
    .wr_addr_a (ptr_r),
    .wr_data_a (i2c_din),
    .wr_en_b   (host_we_s),
    .wr_addr_b (host_wr_addr),
    .wr_data_b (host_wr_data),
    .rd_addr_a (ptr_r),
    .rd_data_a (i2c_send_data),
    .rd_addr_b (host_rd_addr),
    .rd_data_b (host_rd_data)
  );

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl with a strobe/collision scoreboard monitor.
module tb_i2c_reg_ctrl;

  localparam int NR = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i2c_start_cond, i2c_stop_cond, i2c_dev_addr_match, i2c_ack, i2c_nack;
  logic [7:0]    i2c_din;
  logic [7:0]    i2c_send_data;
  logic          host_wr_en;
  logic [AW-1:0] host_wr_addr;
  logic [7:0]    host_wr_data;
  logic          host_wr_collision;
  logic [AW-1:0] host_rd_addr;
  logic [7:0]    host_rd_data;
  logic          i2c_wr_strobe;
  logic [AW-1:0] i2c_wr_addr;
  logic          busy;
  logic [15:0]   xfer_count;

  int vectors = 0;
  int miscompares = 0;
  logic [AW-1:0] exp_strobe_q[$];
  int            exp_coll_q[$];

  i2c_reg_ctrl #(.NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .i2c_start_cond(i2c_start_cond), .i2c_stop_cond(i2c_stop_cond),
    .i2c_dev_addr_match(i2c_dev_addr_match), .i2c_ack(i2c_ack), .i2c_nack(i2c_nack),
    .i2c_din(i2c_din), .i2c_send_data(i2c_send_data),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_wr_collision(host_wr_collision),
    .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
    .i2c_wr_strobe(i2c_wr_strobe), .i2c_wr_addr(i2c_wr_addr),
    .busy(busy), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe/collision pulse must match a queued expectation.
  always @(negedge clk) begin
    if (i2c_wr_strobe) begin
      check("wr_strobe_expected", 32'(exp_strobe_q.size() != 0), 32'd1);
      if (exp_strobe_q.size() != 0) check("wr_strobe_addr", 32'(i2c_wr_addr), 32'(exp_strobe_q.pop_front()));
    end
    if (host_wr_collision) begin
      check("collision_expected", 32'(exp_coll_q.size() != 0), 32'd1);
      if (exp_coll_q.size() != 0) void'(exp_coll_q.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    @(negedge clk); i2c_start_cond = 1'b1;
    @(negedge clk); i2c_start_cond = 1'b0;
    tick(1);
  endtask

  task automatic do_stop();
    @(negedge clk); i2c_stop_cond = 1'b1;
    @(negedge clk); i2c_stop_cond = 1'b0;
    tick(1);
  endtask

  task automatic addr_phase(input logic [7:0] a);
    @(negedge clk); i2c_din = a; i2c_dev_addr_match = 1'b1;
    @(negedge clk); i2c_dev_addr_match = 1'b0;
    tick(1);
    @(negedge clk); i2c_ack = 1'b1;
    @(negedge clk); i2c_ack = 1'b0;
    tick(1);
  endtask

  task automatic byte_ack(input logic [7:0] b, input bit is_nack);
    @(negedge clk); i2c_din = b; i2c_ack = ~is_nack; i2c_nack = is_nack;
    @(negedge clk); i2c_ack = 1'b0; i2c_nack = 1'b0;
    tick(2);
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic [AW-1:0] exp_addr);
    exp_strobe_q.push_back(exp_addr);
    byte_ack(b, 1'b0);
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk); host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
    @(negedge clk); host_wr_en = 1'b0;
  endtask

  task automatic host_check(input string name, input logic [AW-1:0] a, input logic [7:0] exp);
    @(negedge clk); host_rd_addr = a;
    @(negedge clk); check(name, 32'(host_rd_data), 32'(exp));
  endtask

  initial begin
    rst = 1'b1;
    i2c_start_cond = 1'b0; i2c_stop_cond = 1'b0; i2c_dev_addr_match = 1'b0;
    i2c_ack = 1'b0; i2c_nack = 1'b0; i2c_din = 8'h00;
    host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = 8'h00; host_rd_addr = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_xfer_count", 32'(xfer_count), 32'd0);
    check("rst_send_data", 32'(i2c_send_data), 32'd0);
    check("rst_host_rd_data", 32'(host_rd_data), 32'd0);
    check("rst_strobe", 32'(i2c_wr_strobe), 32'd0);
    check("rst_collision", 32'(host_wr_collision), 32'd0);

    host_write(4'd0, 8'hA5);
    host_write(4'd1, 8'h5A);
    host_write(4'd2, 8'hC3);
    host_write(4'd15, 8'hF0);
    host_check("host_wr_reg2", 4'd2, 8'hC3);

    // Write 0xA0, ptr 3, data 0x11, 0x22, stop.
    do_start();
    addr_phase(8'hA0);
    check("busy_in_ptr", 32'(busy), 32'd1);
    byte_ack(8'h03, 1'b0);
    wr_byte(8'h11, 4'd3);
    wr_byte(8'h22, 4'd4);
    do_stop();
    check("t1_xfer_count", 32'(xfer_count), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    host_check("t1_reg3", 4'd3, 8'h11);
    host_check("t1_reg4", 4'd4, 8'h22);

    // Ptr 0x0F, repeated start, read three bytes with ack, ack, nack.
    do_start();
    addr_phase(8'hA0);
    byte_ack(8'h0F, 1'b0);
    do_start();
    check("t2_count_rep_start", 32'(xfer_count), 32'd2);
    addr_phase(8'hA1);
    check("t2_byte0", 32'(i2c_send_data), 32'hF0);
    byte_ack(8'h00, 1'b0);
    check("t2_byte1", 32'(i2c_send_data), 32'hA5);
    byte_ack(8'h00, 1'b0);
    check("t2_byte2", 32'(i2c_send_data), 32'h5A);
    byte_ack(8'h00, 1'b1);
    check("t2_final_ptr_data", 32'(i2c_send_data), 32'hC3);
    check("t2_idle", 32'(busy), 32'd0);
    do_stop();
    check("t2_xfer_count", 32'(xfer_count), 32'd2);

    // Mismatched address 0xB0: data acks must be ignored.
    do_start();
    @(negedge clk); i2c_din = 8'hB0;
    tick(2);
    byte_ack(8'h99, 1'b0);
    byte_ack(8'h98, 1'b0);
    check("t3_busy_in_addr", 32'(busy), 32'd1);
    do_stop();
    check("t3_xfer_count", 32'(xfer_count), 32'd2);
    host_check("t3_reg2", 4'd2, 8'hC3);
    host_check("t3_reg3", 4'd3, 8'h11);

    // Host write to 5 collides with I2C write to 4.
    do_start();
    addr_phase(8'hA0);
    byte_ack(8'h04, 1'b0);
    exp_strobe_q.push_back(4'd4);
    exp_coll_q.push_back(1);
    @(negedge clk);
    i2c_din = 8'h44; i2c_ack = 1'b1;
    host_wr_en = 1'b1; host_wr_addr = 4'd5; host_wr_data = 8'h77;
    @(negedge clk);
    i2c_ack = 1'b0; host_wr_en = 1'b0;
    tick(2);
    do_stop();
    check("t4_xfer_count", 32'(xfer_count), 32'd3);
    host_check("t4_reg4", 4'd4, 8'h44);
    host_check("t4_reg5", 4'd5, 8'h00);

    // Pointer byte 0x37 keeps only the low bits.
    do_start();
    addr_phase(8'hA0);
    byte_ack(8'h37, 1'b0);
    wr_byte(8'h66, 4'd7);
    do_stop();
    check("t5_xfer_count", 32'(xfer_count), 32'd4);
    host_check("t5_reg7", 4'd7, 8'h66);

    // Async reset in WDATA after one byte.
    do_start();
    addr_phase(8'hA0);
    byte_ack(8'h08, 1'b0);
    wr_byte(8'h55, 4'd8);
    #2 rst = 1'b1;
    #1;
    check("t6_busy_rst", 32'(busy), 32'd0);
    check("t6_count_rst", 32'(xfer_count), 32'd0);
    check("t6_send_rst", 32'(i2c_send_data), 32'd0);
    @(negedge clk); rst = 1'b0;
    host_check("t6_reg8", 4'd8, 8'h00);
    host_check("t6_reg3", 4'd3, 8'h00);
    byte_ack(8'h77, 1'b0);
    do_start();
    addr_phase(8'hA0);
    byte_ack(8'h01, 1'b0);
    wr_byte(8'h3C, 4'd1);
    do_stop();
    check("t6_xfer_count", 32'(xfer_count), 32'd1);
    host_check("t6_reg1", 4'd1, 8'h3C);
    host_check("t6_reg0", 4'd0, 8'h00);

    tick(2);
    check("strobe_queue_drained", 32'(exp_strobe_q.size()), 32'd0);
    check("collision_queue_drained", 32'(exp_coll_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
